// File: rtl/apb_image_slave.sv
// apb_image_slave: APB responder for CatRecognizer. Holds the image
// array, control/status register and start/done handshake with the core.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   PSEL..PRDATA    - APB slave (zero wait states, no PREADY)
//   core_addr       - image word index requested by the core
//   core_data       - registered image word, 1-cycle latency
//   start_pulse     - one-cycle start to the core
//   core_done       - one-cycle completion pulse from the core
//   core_result     - cat/no-cat, valid with core_done
//   busy            - core running
module apb_image_slave #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int ImageWords      = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Addr_Depth-1:0] PADDR,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
  input  logic [11:0]                core_addr,
  output logic [Amba_Word-1:0]       core_data,
  output logic                       start_pulse,
  input  logic                       core_done,
  input  logic                       core_result,
  output logic                       busy
);

  localparam int IW = $clog2(ImageWords);
  localparam int AD = Amba_Addr_Depth;

  localparam logic [AD-1:0] LastAddr  = AD'(ImageWords);
  localparam logic [AD-1:0] OneAddr   = AD'(1);
  localparam logic [12:0]   CoreLimit = 13'(ImageWords);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0] state_q, state_d;

  logic [Amba_Word-1:0] prdata_q, prdata_d;
  logic [Amba_Word-1:0] cdata_q, cdata_d;

  logic start_q, start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic res_q, res_d;
  logic err_q, err_d;

  logic [Amba_Word-1:0] mem_q [ImageWords];

  logic          addr_zero;
  logic          addr_img;
  logic [IW-1:0] mem_idx;
  logic          mem_we;
  logic          commit;
  logic          rd_cap;

  logic [Amba_Word-1:0] status;
  logic [Amba_Word-1:0] rd_mux;

  always_comb begin
    addr_zero = (PADDR == '0);
    addr_img  = !addr_zero && (PADDR <= LastAddr);
    mem_idx   = IW'(PADDR - OneAddr);
    status    = Amba_Word'({err_q, res_q, done_q,
                            busy_q, 1'b0});
    rd_mux    = '0;
    if (addr_zero) begin
      rd_mux = status;
    end else if (addr_img) begin
      rd_mux = mem_q[mem_idx];
    end
  end

  // A write lands only on the edge entering ACCESS, from SETUP
  // or from IDLE when the setup cycle was skipped.
  always_comb begin
    commit = !rst && PSEL && PENABLE && PWRITE &&
             ((state_q == IDLE) || (state_q == SETUP));
    // Reads sample during setup so PRDATA is stable in access.
    rd_cap = PSEL && !PWRITE &&
             (!PENABLE || (state_q == IDLE));
  end

  always_comb begin
    state_d = state_q;
    if (!PSEL) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = PENABLE ? ACCESS : SETUP;
        SETUP:   state_d = PENABLE ? ACCESS : SETUP;
        ACCESS:  state_d = PENABLE ? HOLD : SETUP;
        HOLD:    state_d = PENABLE ? HOLD : SETUP;
        default: state_d = IDLE;
      endcase
    end
  end

  // core_done is applied first so a same-edge start overrides it.
  always_comb begin
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    res_d   = res_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (core_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      res_d  = core_result;
    end
    if (commit) begin
      unique case (1'b1)
        addr_zero: begin
          if (PWDATA[0]) begin
            if (busy_q) begin
              err_d = 1'b1;
            end else begin
              start_d = 1'b1;
              busy_d  = 1'b1;
              done_d  = 1'b0;
            end
          end else begin
            done_d = 1'b0;
            err_d  = 1'b0;
          end
        end
        addr_img: begin
          if (busy_q) begin
            err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    prdata_d = rd_cap ? rd_mux : prdata_q;
    cdata_d  = '0;
    if ({1'b0, core_addr} < CoreLimit) begin
      cdata_d = mem_q[core_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prdata_q <= '0;
      cdata_q  <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prdata_q <= prdata_d;
      cdata_q  <= cdata_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  // Image array is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= PWDATA;
    end
  end

  assign PRDATA      = prdata_q;
  assign core_data   = cdata_q;
  assign start_pulse = start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_apb_image_slave.sv
// tb_apb_image_slave: directed and randomized checks of
// apb_image_slave against a transaction-level model.
module tb_apb_image_slave;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [12:0] PADDR;
  logic [23:0] PWDATA, PRDATA;
  logic [11:0] core_addr;
  logic [23:0] core_data;
  logic        start_pulse, core_done, core_result, busy;

  apb_image_slave dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .core_addr(core_addr), .core_data(core_data),
    .start_pulse(start_pulse), .core_done(core_done),
    .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;

  always @(negedge clk) if (start_pulse === 1'b1) start_cnt++;

  logic [23:0] m_mem [N];
  bit          m_vld [N];
  bit m_busy, m_done, m_res, m_err;
  int exp_starts = 0;

  function automatic logic [23:0] m_status();
    return {19'b0, m_err, m_res, m_done, m_busy, 1'b0};
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_done = 0; m_res = 0; m_err = 0;
  endfunction

  function automatic void m_write(int a, logic [23:0] d);
    if (a == 0) begin
      if (d[0]) begin
        if (m_busy) m_err = 1;
        else begin
          m_busy = 1; m_done = 0; exp_starts++;
        end
      end else begin
        m_done = 0; m_err = 0;
      end
    end else if (a <= N) begin
      if (m_busy) m_err = 1;
      else begin
        m_mem[a-1] = d; m_vld[a-1] = 1;
      end
    end else m_err = 1;
  endfunction

  function automatic bit m_known(int a);
    if (a == 0 || a > N) return 1;
    return m_vld[a-1];
  endfunction

  function automatic logic [23:0] m_read(int a);
    if (a == 0) return m_status();
    if (a > N) return 24'h0;
    return m_mem[a-1];
  endfunction

  function automatic int pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 0;
    if (r < 7) return $urandom_range(1, 12);
    if (r == 7) return $urandom_range(4090, 4096);
    if (r == 8) return $urandom_range(4097, 8191);
    return $urandom_range(1, 4096);
  endfunction

  task automatic apb_write(input int a, input logic [23:0] d,
                           input bit keep);
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1;
    PADDR = 13'(a); PWDATA = d;
    @(negedge clk);
    PENABLE = 1;
    if (!keep) begin
      @(negedge clk);
      PSEL = 0; PENABLE = 0;
    end
    m_write(a, d);
  endtask

  task automatic apb_read(input int a, output logic [23:0] d,
                          input bit keep);
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 13'(a);
    @(negedge clk);
    PENABLE = 1;
    d = PRDATA;
    if (!keep) begin
      @(negedge clk);
      PSEL = 0; PENABLE = 0;
    end
  endtask

  task automatic pulse_done(input bit r);
    @(negedge clk);
    core_done = 1; core_result = r;
    @(negedge clk);
    core_done = 0; core_result = 0;
    m_busy = 0; m_done = 1; m_res = r;
  endtask

  task automatic test_reset();
    logic [23:0] d;
    rst = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (PRDATA !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_prdata got %h want 000000", PRDATA);
    end
    n_chk++;
    if (core_data !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_core_data got %h want 000000", core_data);
    end
    n_chk++;
    if (busy !== 1'b0 || start_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_start got %b%b want 00",
               busy, start_pulse);
    end
    rst = 0;
    m_reset();
    apb_read(0, d, 0);
    n_chk++;
    if (d !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_status got %h want 000000", d);
    end
  endtask

  task automatic test_image();
    logic [23:0] d;
    apb_write(1, 24'h0A0B0C, 0);
    apb_write(4096, 24'hFFEE01, 0);
    apb_write(5, 24'h555555, 0);
    apb_read(1, d, 0);
    n_chk++;
    if (d !== 24'h0A0B0C) begin
      n_fail++;
      $display("FAIL img_rd1 got %h want 0a0b0c", d);
    end
    apb_read(4096, d, 0);
    n_chk++;
    if (d !== 24'hFFEE01) begin
      n_fail++;
      $display("FAIL img_rd4096 got %h want ffee01", d);
    end
    @(negedge clk); core_addr = 12'd0;
    @(negedge clk);
    n_chk++;
    if (core_data !== 24'h0A0B0C) begin
      n_fail++;
      $display("FAIL core_rd0 got %h want 0a0b0c", core_data);
    end
    core_addr = 12'd4095;
    @(negedge clk);
    n_chk++;
    if (core_data !== 24'hFFEE01) begin
      n_fail++;
      $display("FAIL core_rd4095 got %h want ffee01", core_data);
    end
  endtask

  task automatic test_hold_start();
    logic [23:0] d;
    int s0;
    s0 = start_cnt;
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1;
    PADDR = 13'd0; PWDATA = 24'h000001;
    @(negedge clk); PENABLE = 1;
    repeat (3) @(negedge clk);
    PSEL = 0; PENABLE = 0;
    m_write(0, 24'h000001);
    repeat (3) @(negedge clk);
    n_chk++;
    if (start_cnt - s0 != 1) begin
      n_fail++;
      $display("FAIL hold_start_pulses got %0d want 1",
               start_cnt - s0);
    end
    apb_read(0, d, 0);
    n_chk++;
    if (d !== 24'h000002) begin
      n_fail++;
      $display("FAIL hold_status got %h want 000002", d);
    end
  endtask

  task automatic test_busy_err();
    logic [23:0] d;
    apb_write(5, 24'h123456, 0);
    apb_read(5, d, 0);
    n_chk++;
    if (d !== m_read(5)) begin
      n_fail++;
      $display("FAIL busy_drop got %h want %h", d, m_read(5));
    end
    apb_read(0, d, 0);
    n_chk++;
    if (d !== 24'h000012) begin
      n_fail++;
      $display("FAIL busy_err_status got %h want 000012", d);
    end
    pulse_done(1);
    apb_read(0, d, 0);
    n_chk++;
    if (d !== 24'h00001C) begin
      n_fail++;
      $display("FAIL done_status got %h want 00001c", d);
    end
  endtask

  task automatic test_clear();
    logic [23:0] d;
    apb_write(0, 24'h000000, 0);
    apb_read(0, d, 0);
    n_chk++;
    if (d !== 24'h000008) begin
      n_fail++;
      $display("FAIL clear_status got %h want 000008", d);
    end
    apb_write(5000, 24'h777777, 0);
    apb_read(5000, d, 0);
    n_chk++;
    if (d !== 24'h000000) begin
      n_fail++;
      $display("FAIL oor_read got %h want 000000", d);
    end
    apb_read(0, d, 0);
    n_chk++;
    if (d !== 24'h000018) begin
      n_fail++;
      $display("FAIL oor_err_status got %h want 000018", d);
    end
    apb_read(5, d, 0);
    n_chk++;
    if (d !== 24'h555555) begin
      n_fail++;
      $display("FAIL oor_no_change got %h want 555555", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    apb_write(0, 24'h000000, 1);
    apb_write(3, 24'h313131, 1);
    apb_read(3, d, 1);
    n_chk++;
    if (d !== 24'h313131) begin
      n_fail++;
      $display("FAIL b2b_rd3 got %h want 313131", d);
    end
    apb_write(6, 24'h616161, 1);
    apb_read(6, d, 0);
    n_chk++;
    if (d !== 24'h616161) begin
      n_fail++;
      $display("FAIL b2b_rd6 got %h want 616161", d);
    end
    @(negedge clk);
    PSEL = 1; PENABLE = 1; PWRITE = 1;
    PADDR = 13'd7; PWDATA = 24'h707070;
    @(negedge clk); PSEL = 0; PENABLE = 0;
    m_write(7, 24'h707070);
    apb_read(7, d, 0);
    n_chk++;
    if (d !== 24'h707070) begin
      n_fail++;
      $display("FAIL nosetup_wr got %h want 707070", d);
    end
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1;
    PADDR = 13'd0; PWDATA = 24'h000001;
    @(negedge clk);
    PENABLE = 1; core_done = 1; core_result = 0;
    @(negedge clk);
    PSEL = 0; PENABLE = 0; core_done = 0;
    m_write(0, 24'h000001);
    apb_read(0, d, 0);
    n_chk++;
    if ((d & 24'h6) !== 24'h2) begin
      n_fail++;
      $display("FAIL start_vs_done got %h want busy=1 done=0", d);
    end
    pulse_done(0);
  endtask

  task automatic test_reset_mid();
    logic [23:0] d;
    apb_write(2, 24'h111111, 0);
    apb_write(5000, 24'h0, 0);
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1;
    PADDR = 13'd2; PWDATA = 24'hABCDEF;
    @(negedge clk); PENABLE = 1; rst = 1;
    @(negedge clk); PSEL = 0; PENABLE = 0; rst = 0;
    m_reset();
    apb_read(2, d, 0);
    n_chk++;
    if (d !== 24'h111111) begin
      n_fail++;
      $display("FAIL rst_mid_mem got %h want 111111", d);
    end
    apb_read(0, d, 0);
    n_chk++;
    if (d !== 24'h000000) begin
      n_fail++;
      $display("FAIL rst_mid_status got %h want 000000", d);
    end
    apb_write(0, 24'h000001, 0);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    m_reset();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
  endtask

  task automatic test_random();
    logic [23:0] d, w;
    int a, op, s0;
    bit keep;
    s0 = start_cnt - exp_starts;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      keep = 1'($urandom_range(0, 1));
      if (op < 4) begin
        a = pick_addr();
        w = 24'($urandom);
        if (a == 0 && $urandom_range(0, 2) != 0) w[0] = 1'b0;
        apb_write(a, w, keep);
      end else if (op < 7) begin
        a = pick_addr();
        apb_read(a, d, keep);
        if (m_known(a)) begin
          n_chk++;
          if (d !== m_read(a)) begin
            n_fail++;
            $display("FAIL rnd_read addr %0d got %h want %h",
                     a, d, m_read(a));
          end
        end
      end else if (op == 7) begin
        if (m_busy) pulse_done(1'($urandom_range(0, 1)));
      end else begin
        a = ($urandom_range(0, 3) == 0) ?
            $urandom_range(4088, 4095) : $urandom_range(0, 11);
        @(negedge clk); core_addr = 12'(a);
        @(negedge clk);
        if (m_vld[a]) begin
          n_chk++;
          if (core_data !== m_mem[a]) begin
            n_fail++;
            $display("FAIL rnd_core idx %0d got %h want %h",
                     a, core_data, m_mem[a]);
          end
        end
      end
    end
    @(negedge clk); PSEL = 0; PENABLE = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (start_cnt - exp_starts != s0) begin
      n_fail++;
      $display("FAIL rnd_starts got %0d want %0d",
               start_cnt - s0, exp_starts);
    end
    apb_read(0, d, 0);
    n_chk++;
    if (d !== m_status()) begin
      n_fail++;
      $display("FAIL rnd_status got %h want %h", d, m_status());
    end
  endtask

  initial begin
    rst = 1; PSEL = 0; PENABLE = 0; PWRITE = 0;
    PADDR = '0; PWDATA = '0; core_addr = '0;
    core_done = 0; core_result = 0;
    for (int i = 0; i < N; i++) m_vld[i] = 0;
    test_reset();
    test_image();
    test_hold_start();
    test_busy_err();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_image_slave.md
Name: apb_image_slave

Overview:
- APB responder that terminates the CPU-side bus of CatRecognizer.
- Decodes PADDR. Address 0 is the control/status register. Addresses 1..ImageWords each hold one image word of three packed 8-bit pixels.
- Stores image words in an internal register array and issues a one-cycle start pulse to the recognition core.
- Exposes busy/done/result status back to the CPU over PRDATA.

Parameters:
Amba_Word, 24, APB data width; holds 3 pixels {p[3k-3],p[3k-2],p[3k-1]}, MSB first
Amba_Addr_Depth, 13, PADDR width
ImageWords, 4096, number of image words (12288 pixels / 3)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable (access phase)
PWRITE  in  1  1=write, 0=read
PADDR  in  Amba_Addr_Depth  word address
PWDATA  in  Amba_Word  write data
PRDATA  out  Amba_Word  read data, registered
core_addr  in  12  image word index 0..ImageWords-1 requested by core (maps to APB address core_addr+1)
core_data  out  Amba_Word  image word, registered, 1-cycle latency
start_pulse  out  1  one-cycle start to core
core_done  in  1  one-cycle pulse from core, computation finished
core_result  in  1  cat/no-cat, valid with core_done
busy  out  1  core running

Behaviour:
- Reset (rst=1 at clk edge): PRDATA=0, core_data=0, start_pulse=0, busy=0, done=0, result=0, err=0, FSM->IDLE. Image array is not cleared.
- Control register (addr 0), read value {zeros, err[4], result[3], done[2], busy[1], 1'b0}. Bit0 always reads 0.
- FSM has four states; one APB access executes exactly once per PSEL/PENABLE episode (no PREADY, zero wait states).
  - IDLE: PSEL&!PENABLE -> SETUP.
  - SETUP: for a read, capture the read mux into PRDATA at this edge, so PRDATA is valid throughout the access phase. Then PSEL&PENABLE -> ACCESS.
  - ACCESS: writes commit on the edge entering ACCESS. Then PENABLE still high -> HOLD; PSEL&!PENABLE -> SETUP (back-to-back); !PSEL -> IDLE.
  - HOLD: a held PENABLE does not re-commit. PENABLE low -> SETUP if PSEL, else IDLE.
  - Any state, PSEL=0 -> IDLE.
  - PSEL&PENABLE seen in IDLE (missing setup): treated as setup+access in one, write committed once, -> ACCESS.
- Write addr 0:
  - PWDATA[0]=1 and busy=0: start_pulse=1 for exactly one cycle (next cycle); busy<=1; done<=0.
  - PWDATA[0]=1 and busy=1: ignored, err<=1.
  - PWDATA[0]=0: clears done and err. Does not touch busy or result.
- Write addr 1..ImageWords: busy=0 -> mem[PADDR-1]<=PWDATA. busy=1 -> dropped, err<=1.
- Write addr > ImageWords: dropped, err<=1.
- Read addr > ImageWords: returns 0, no error.
- core_done=1: busy<=0, done<=1, result<=core_result, same edge. core_done on the same edge as a start write: start wins, done stays 0.
- core_data <= mem[core_addr] every cycle. core_addr >= ImageWords returns 0.
- CPU write and core read to the same word in the same cycle: core_data returns the old contents.
- rst asserted mid-access: FSM->IDLE, the pending write is discarded, busy cleared. The core must be reset alongside.

Test Plan:
- Reset, then read addr 0 -> PRDATA=24'h000000; busy=0, start_pulse=0.
- Write addr 1 = 24'h0A0B0C, addr 4096 = 24'hFFEE01; read both back -> exact values; core_addr=0 -> core_data=24'h0A0B0C one cycle later.
- Hold PENABLE high 3 cycles on a write of 24'h000001 to addr 0 -> start_pulse high exactly 1 cycle; err stays 0.
- With busy=1, write addr 5 = 24'h123456 -> mem[4] unchanged; status reads 24'h000012 (err=1, busy=1). Then core_done=1 with core_result=1 -> status reads 24'h00001C.
- Write 24'h000000 to addr 0 -> status 24'h000008 (done and err cleared, result=1 retained). Write to addr 5000 -> err=1, no array change.
- Assert rst during the ACCESS phase of a write to addr 2 = 24'hABCDEF -> mem[1] unchanged, all status bits 0.
